// File: rtl/random_gen.sv
// -----------------------------------------------------------------------------
// random_gen -- LFSR-based random number source with a valid/ready output.
//
// A 32-bit Fibonacci LFSR (taps 31,21,1,0) free-runs on every clock edge that
// is not a reset or a seed load. After reset or a seed load the generator
// discards WARMUP steps (WARM state), then presents draws on a valid/ready
// interface (READY state). Each draw is the 32-bit LFSR state XOR-folded down
// to WIDTH bits. The held draw stays stable while the consumer stalls, even
// though the LFSR keeps stepping underneath it.
//
// Parameters
//   WIDTH   : rand_out width, 1..32
//   SEED    : reset seed, also substituted for an all-zero seed_in (nonzero)
//   WARMUP  : LFSR steps discarded after reset/seed load, 1..255
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst_n      in   1      synchronous active-low reset (overrides seed_load)
//   seed_load  in   1      load seed_in into the LFSR this edge (no step)
//   seed_in    in   32     new seed value; 0 selects SEED
//   out_ready  in   1      consumer accepts rand_out this cycle
//   out_valid  out  1      rand_out holds a valid draw
//   rand_out   out  WIDTH  current random draw
//   busy       out  1      high while warming up
//   draws      out  16     count of accepted draws, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module random_gen #(
  parameter int          WIDTH  = 8,
  parameter logic [31:0] SEED   = 32'h0000_0001,
  parameter int          WARMUP = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic             busy,
  output logic [15:0]      draws
);

  typedef enum logic {
    ST_WARM  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [7:0] WARMUP_LAST = 8'(WARMUP - 1);

  // Fold 32 bits down to WIDTH: output bit i is the parity of every
  // input bit j with j mod WIDTH == i.
  function automatic logic [WIDTH-1:0] fold(input logic [31:0] x);
    logic [WIDTH-1:0] f;
    f = '0;
    for (int j = 0; j < 32; j++) begin
      f[j % WIDTH] = f[j % WIDTH] ^ x[j];
    end
    return f;
  endfunction

  state_t           r_state;
  logic [31:0]      r_lfsr;
  logic [7:0]       r_wc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_rand;
  logic [15:0]      r_draws;

  state_t           w_state_next;
  logic [31:0]      w_lfsr_step;
  logic [31:0]      w_lfsr_next;
  logic [7:0]       w_wc_next;
  logic             w_valid_next;
  logic [WIDTH-1:0] w_rand_next;
  logic [15:0]      w_draws_next;

  assign w_lfsr_step = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

  // NOTE: every signal gets its hold/default value before any branch, so no
  // path through this block leaves a signal unassigned and no latch is built.
  always_comb begin
    w_state_next = r_state;
    w_lfsr_next  = w_lfsr_step;
    w_wc_next    = r_wc;
    w_valid_next = r_out_valid;
    w_rand_next  = r_rand;
    w_draws_next = r_draws;

    if (seed_load) begin
      // A seed load wins over any same-edge transfer; that transfer is dropped.
      // An all-zero seed would lock the LFSR, so SEED stands in for it.
      w_lfsr_next  = (seed_in == 32'd0) ? SEED : seed_in;
      w_wc_next    = 8'd0;
      w_state_next = ST_WARM;
      w_valid_next = 1'b0;
      w_draws_next = 16'd0;
    end else begin
      unique case (r_state)
        ST_WARM: begin
          if (r_wc == WARMUP_LAST) begin
            w_state_next = ST_READY;
            w_wc_next    = 8'd0;
            w_valid_next = 1'b1;
            w_rand_next  = fold(w_lfsr_step);
          end else begin
            w_wc_next = r_wc + 8'd1;
          end
        end
        ST_READY: begin
          // Refill the output register whenever it is empty or being drained;
          // otherwise the draw is held while the LFSR keeps running.
          if (!r_out_valid || out_ready) begin
            w_rand_next = fold(w_lfsr_step);
          end
          if (r_out_valid && out_ready) begin
            w_draws_next = r_draws + 16'd1;
          end
        end
        default: begin
          w_state_next = ST_WARM;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WARM;
      r_lfsr      <= SEED;
      r_wc        <= 8'd0;
      r_out_valid <= 1'b0;
      r_rand      <= '0;
      r_draws     <= 16'd0;
    end else begin
      r_state     <= w_state_next;
      r_lfsr      <= w_lfsr_next;
      r_wc        <= w_wc_next;
      r_out_valid <= w_valid_next;
      r_rand      <= w_rand_next;
      r_draws     <= w_draws_next;
    end
  end

  assign out_valid = r_out_valid;
  assign rand_out  = r_rand;
  assign draws     = r_draws;
  assign busy      = (r_state == ST_WARM);

endmodule

// File: tb/tb_random_gen.sv
// -----------------------------------------------------------------------------
// tb_random_gen -- self-checking bench for random_gen.
//
// dut8 : WIDTH=8, WARMUP=2, SEED=1 -- hand-computed vector table, stall
//        sequence, and randomized stimulus against a behavioural model.
// dut4 : WIDTH=4, defaults otherwise -- 70000 back-to-back transfers with the
//        draw counter wrapping.
// -----------------------------------------------------------------------------
module tb_random_gen;

  localparam logic [31:0] SEED8   = 32'h0000_0001;
  localparam int          WARMUP8 = 2;
  localparam logic [31:0] SEED4   = 32'h0000_0001;
  localparam int          WARMUP4 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut8 signals
  logic        rst_n8, seed_load8, out_ready8;
  logic [31:0] seed_in8;
  logic        out_valid8, busy8;
  logic [7:0]  rand_out8;
  logic [15:0] draws8;

  // dut4 signals
  logic        rst_n4, seed_load4, out_ready4;
  logic [31:0] seed_in4;
  logic        out_valid4, busy4;
  logic [3:0]  rand_out4;
  logic [15:0] draws4;

  random_gen #(.WIDTH(8), .SEED(SEED8), .WARMUP(WARMUP8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .seed_load(seed_load8), .seed_in(seed_in8),
    .out_ready(out_ready8), .out_valid(out_valid8), .rand_out(rand_out8),
    .busy(busy8), .draws(draws8)
  );

  random_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .seed_load(seed_load4), .seed_in(seed_in4),
    .out_ready(out_ready4), .out_valid(out_valid4), .rand_out(rand_out4),
    .busy(busy4), .draws(draws4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // LFSR step: new bit is the parity of the tapped bits (31,21,1,0).
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  function automatic logic [31:0] fold_ref(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < 32; j++) begin
      if (x[j]) r = r ^ (32'd1 << (j % w));
    end
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] steps;   // steps taken since the last reset / seed load
    logic        valid;
    logic [31:0] rnd;
    logic [31:0] draws;
  } model_t;

  // One clock edge of the generator, described by its observable rules:
  // warm-up ends once WARMUP steps have been taken since the last (re)seed.
  function automatic model_t model_edge(input model_t m, input int w, input int warmup,
                                        input logic [31:0] seedp, input logic rst_n_i,
                                        input logic load, input logic [31:0] seed,
                                        input logic ready);
    model_t n;
    n = m;
    if (!rst_n_i) begin
      n = '{s: seedp, steps: 32'd0, valid: 1'b0, rnd: 32'd0, draws: 32'd0};
    end else if (load) begin
      n.s     = (seed == 32'd0) ? seedp : seed;
      n.steps = 32'd0;
      n.valid = 1'b0;
      n.draws = 32'd0;
    end else begin
      n.s = lfsr_next(m.s);
      if (m.steps < 32'(warmup)) n.steps = m.steps + 32'd1;
      if (m.steps < 32'(warmup)) begin
        if (n.steps == 32'(warmup)) begin
          n.valid = 1'b1;
          n.rnd   = fold_ref(n.s, w);
        end
      end else begin
        if (m.valid && ready) n.draws = (m.draws + 32'd1) % 32'd65536;
        if (!m.valid || ready) n.rnd = fold_ref(n.s, w);
      end
    end
    return n;
  endfunction

  function automatic logic model_busy(input model_t m, input int warmup);
    return m.steps < 32'(warmup);
  endfunction

  model_t m8, m4;

  // Apply one edge to dut8 and compare every output to the model.
  task automatic cycle8(input logic r, input logic ld, input logic [31:0] sd, input logic rdy);
    rst_n8 = r; seed_load8 = ld; seed_in8 = sd; out_ready8 = rdy;
    @(posedge clk);
    #1;
    m8 = model_edge(m8, 8, WARMUP8, SEED8, r, ld, sd, rdy);
    check("m8_valid", {31'd0, out_valid8}, {31'd0, m8.valid});
    check("m8_rand",  {24'd0, rand_out8}, m8.rnd);
    check("m8_busy",  {31'd0, busy8}, {31'd0, model_busy(m8, WARMUP8)});
    check("m8_draws", {16'd0, draws8}, m8.draws);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        rst_n;
    logic        load;
    logic [31:0] seed;
    logic        ready;
    logic        valid;
    logic [7:0]  rnd;
    logic        busy;
    logic [15:0] draws;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  initial begin
    logic [31:0] s0;
    logic [31:0] s_exp;
    logic [7:0]  held_rand;
    logic [15:0] held_draws;
    logic        r, ld, rdy;
    logic [31:0] sd;

    rst_n8 = 1'b0; seed_load8 = 1'b0; seed_in8 = 32'd0; out_ready8 = 1'b0;
    rst_n4 = 1'b0; seed_load4 = 1'b0; seed_in4 = 32'd0; out_ready4 = 1'b0;

    //          rst load seed           rdy  valid rnd    busy draws
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b1, 16'd0}; // reset
    vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b1, 16'd0}; // s=3
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 8'h06, 1'b0, 16'd0}; // s=6 ready
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h0D, 1'b0, 16'd1}; // s=D xfer
    vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 8'h0D, 1'b0, 16'd1}; // s=1B hold
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h36, 1'b0, 16'd2}; // s=36 xfer
    vecs[6]  = '{1'b0, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 8'h00, 1'b1, 16'd0}; // rst+load
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b1, 16'd0}; // s=3
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h06, 1'b0, 16'd0}; // s=6, no xfer
    vecs[9]  = '{1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 8'h06, 1'b1, 16'd0}; // zero seed
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h06, 1'b1, 16'd0}; // s=3
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h06, 1'b0, 16'd0}; // s=6 ready
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h0D, 1'b0, 16'd1}; // s=D xfer
    vecs[13] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 8'h0D, 1'b1, 16'd0}; // load seed
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 8'h0D, 1'b1, 16'd0}; // s=1
    vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 8'h03, 1'b0, 16'd0}; // s=3 ready

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      rst_n8 = vecs[i].rst_n; seed_load8 = vecs[i].load;
      seed_in8 = vecs[i].seed; out_ready8 = vecs[i].ready;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid8}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_rand", i),  {24'd0, rand_out8},  {24'd0, vecs[i].rnd});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy8},      {31'd0, vecs[i].busy});
      check($sformatf("vec%0d_draws", i), {16'd0, draws8},     {16'd0, vecs[i].draws});
    end

    // Model state matching the end of the table: READY, s=3, draw 0x03 held.
    m8 = '{s: 32'h3, steps: 32'(WARMUP8), valid: 1'b1, rnd: 32'h03, draws: 32'd0};

    // ---------------- stall for 10 cycles ----------------
    s0         = m8.s;
    held_rand  = rand_out8;
    held_draws = draws8;
    for (int i = 0; i < 10; i++) begin
      cycle8(1'b1, 1'b0, 32'd0, 1'b0);
      check("stall_rand",  {24'd0, rand_out8}, {24'd0, held_rand});
      check("stall_draws", {16'd0, draws8},    {16'd0, held_draws});
    end
    cycle8(1'b1, 1'b0, 32'd0, 1'b1);
    s_exp = s0;
    for (int i = 0; i < 11; i++) s_exp = lfsr_next(s_exp);
    check("stall_resume_rand", {24'd0, rand_out8}, fold_ref(s_exp, 8));
    check("stall_resume_draws", {16'd0, draws8}, {16'd0, held_draws + 16'd1});

    // ---------------- randomized stimulus ----------------
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) != 0);
      ld  = ($urandom_range(0, 24) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rdy = $urandom_range(0, 1) == 1;
      cycle8(r, ld, sd, rdy);
    end

    // ---------------- WIDTH=4, 70000 transfers ----------------
    check("fold4_12345678", fold_ref(32'h1234_5678, 4), 32'h8);

    rst_n4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    m4 = model_edge(m4, 4, WARMUP4, SEED4, 1'b0, 1'b0, 32'd0, 1'b1);
    check("w4_reset_busy", {31'd0, busy4}, 32'd1);
    rst_n4 = 1'b1;
    for (int i = 0; i < WARMUP4; i++) begin
      @(posedge clk);
      #1;
      m4 = model_edge(m4, 4, WARMUP4, SEED4, 1'b1, 1'b0, 32'd0, 1'b1);
    end
    check("w4_warm_valid", {31'd0, out_valid4}, 32'd1);
    check("w4_warm_rand", {28'd0, rand_out4}, m4.rnd);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      #1;
      m4 = model_edge(m4, 4, WARMUP4, SEED4, 1'b1, 1'b0, 32'd0, 1'b1);
      check("w4_rand", {28'd0, rand_out4}, m4.rnd);
    end
    check("w4_draws_model", {16'd0, draws4}, m4.draws);
    check("w4_draws_wrap", {16'd0, draws4}, 32'd4464);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
